keypad_scanner: RTL and testbench

- Upstream stage of the key-interpretation FSM.
- Scans a 4x4 active-low matrix keypad, debounces the key, and encodes it into the `tipo`/`number` pair the FSM consumes.
- Emits exactly one event per physical press, then waits for a debounced release.
- Between events, drives an idle code that the FSM treats as "no valid key".

---
 rtl/keypad_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces one key at a time and
//   encodes it into the (tipo, number) pair used by the key-interpretation FSM.
//   One key_valid strobe per physical press. A debounced release is required
//   before the next key is accepted. Between strobes tipo/number hold the
//   idle code (1, 4'b1110).
//
//   Optional feature macro: KEY_REPEAT_EN. When it is defined, a held digit
//   key auto-repeats after REPEAT_DELAY held samples and then every
//   REPEAT_RATE held samples.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   row_in     keypad rows, active-low, already synchronised
//   col_out    column drive, one-cold
//   tipo       0 = digit, 1 = sign / reset-key
//   number     key code
//   key_valid  one-clock strobe qualifying tipo/number
//   key_held   high while an accepted key is held
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       tipo,
    output logic [3:0] number,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CNT) + 1;
`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
`endif

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HELD} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic              ktipo_q, ktipo_d;
    logic [3:0]        knum_q, knum_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    logic              tipo_q, tipo_d;
    logic [3:0]        number_q, number_d;
    logic              key_valid_q, key_valid_d;
    logic              key_held_q, key_held_d;
`ifdef KEY_REPEAT_EN
    logic [RPT_W-1:0]  rpt_q, rpt_d;
    logic              rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0]  rpt_inc;
    logic [RPT_W-1:0]  rpt_thr;
`endif

    logic              tick;
    logic              smp_key;
    logic [1:0]        smp_row;
    logic [5:0]        map;
    logic [DB_W-1:0]   cnt_inc;

    // {mapped, tipo, number} for a (row, column) position
    function automatic logic [5:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] m;
        m = 6'b0;
        if (c == 2'd3) begin
            case (r)
                2'd0:    m = {1'b1, 1'b1, 4'b1010};
                2'd1:    m = {1'b1, 1'b1, 4'b1011};
                2'd2:    m = {1'b1, 1'b1, 4'b1100};
                default: m = 6'b0;
            endcase
        end else if (r == 2'd3) begin
            if (c == 2'd0)      m = {1'b1, 1'b1, 4'b1111};
            else if (c == 2'd1) m = {1'b1, 1'b0, 4'b0000};
            else                m = 6'b0;
        end else begin
            m = {1'b1, 1'b0, {2'b0, r} * 4'd3 + {2'b0, c} + 4'd1};
        end
        return m;
    endfunction

    // A sample counts as a key only when exactly one row is pulled low;
    // multi-key chords read as "none".
    always_comb begin
        smp_key = 1'b1;
        smp_row = 2'd0;
        case (row_in)
            4'b1110: smp_row = 2'd0;
            4'b1101: smp_row = 2'd1;
            4'b1011: smp_row = 2'd2;
            4'b0111: smp_row = 2'd3;
            default: smp_key = 1'b0;
        endcase
    end

    assign tick    = (div_q == DIV_W'(SCAN_DIV - 1));
    assign map     = key_map(smp_row, col_q);
    assign cnt_inc = (cnt_q == {DB_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
`ifdef KEY_REPEAT_EN
    assign rpt_inc = (rpt_q == {RPT_W{1'b1}}) ? rpt_q : rpt_q + 1'b1;
    assign rpt_thr = rpt_first_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
`endif

    always_comb begin
        state_d     = state_q;
        div_d       = tick ? '0 : div_q + 1'b1;
        col_d       = col_q;
        row_d       = row_q;
        ktipo_d     = ktipo_q;
        knum_d      = knum_q;
        cnt_d       = cnt_q;
        tipo_d      = 1'b1;
        number_d    = 4'b1110;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
        rpt_d       = rpt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (smp_key && map[5]) begin
                        row_d   = smp_row;
                        ktipo_d = map[4];
                        knum_d  = map[3:0];
                        cnt_d   = DB_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (smp_key && smp_row == row_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_W'(DEBOUNCE_CNT)) begin
                            state_d     = EMIT;
                            key_valid_d = 1'b1;
                            tipo_d      = ktipo_q;
                            number_d    = knum_q;
`ifdef KEY_REPEAT_EN
                            rpt_d       = '0;
                            rpt_first_d = 1'b0;
`endif
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            EMIT: begin
                key_held_d = 1'b1;
                cnt_d      = '0;
                state_d    = HELD;
            end
            HELD: begin
                if (tick) begin
                    if (!smp_key) begin
                        if (cnt_inc >= DB_W'(DEBOUNCE_CNT)) begin
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                            state_d    = SCAN;
                            col_d      = col_q + 2'd1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
`ifdef KEY_REPEAT_EN
                        // Only the latched digit key, still held, advances the repeat timer.
                        if (smp_row == row_q && !ktipo_q) begin
                            if (rpt_inc >= rpt_thr) begin
                                rpt_d       = '0;
                                rpt_first_d = 1'b1;
                                state_d     = EMIT;
                                key_valid_d = 1'b1;
                                tipo_d      = ktipo_q;
                                number_d    = knum_q;
                            end else begin
                                rpt_d = rpt_inc;
                            end
                        end
`endif
                    end
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            ktipo_q     <= 1'b1;
            knum_q      <= 4'b1110;
            cnt_q       <= '0;
            tipo_q      <= 1'b1;
            number_q    <= 4'b1110;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_q       <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ktipo_q     <= ktipo_d;
            knum_q      <= knum_d;
            cnt_q       <= cnt_d;
            tipo_q      <= tipo_d;
            number_q    <= number_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign tipo      = tipo_q;
    assign number    = number_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3,
// REPEAT_DELAY=6, REPEAT_RATE=2. A keypad model drives row_in from the
// pressed-key matrix and the current column drive.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        tipo;
    logic [3:0]  number;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;   // bit r*4+c
    int          cyc;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          ev_cnt   = 0;
    int          ev_base;
    logic        last_tipo;
    logic [3:0]  last_num;
    logic        prev_kv  = 1'b0;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_DELAY(6),
        .REPEAT_RATE(2)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .row_in(row_in),
        .col_out(col_out),
        .tipo(tipo),
        .number(number),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // clocks since reset release; scan ticks fall on multiples of 4
    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            if (key_valid) begin
                ev_cnt++;
                last_tipo = tipo;
                last_num  = number;
                n_assert++;
                assert (prev_kv === 1'b0) else begin
                    n_fail++;
                    $error("FAIL kv_back_to_back: observed %b expected 0", prev_kv);
                end
            end
            prev_kv = key_valid;
        end else begin
            prev_kv = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % 4 != 0);
        end
    endtask

    task automatic wait_col(input logic [3:0] v);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (col_out === v) found = 1'b1;
        end
        chk("wait_col_timeout", {7'b0, found}, 8'd1);
    endtask

    task automatic wait_kv();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (key_valid === 1'b1) found = 1'b1;
        end
        chk("wait_kv_timeout", {7'b0, found}, 8'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        pressed = 16'h0;
        #12;
        chk("rst_col",   col_out,   4'b1110);
        chk("rst_tipo",  tipo,      1'b1);
        chk("rst_num",   number,    4'b1110);
        chk("rst_kv",    key_valid, 1'b0);
        chk("rst_held",  key_held,  1'b0);
        @(negedge clk) reset = 1'b1;

        // r1c1 ("5"): enter DEBOUNCE, then reset mid-debounce
        pressed = 16'h0020;
        wait_tick(3);
        chk("deb_col_frozen", col_out, 4'b1101);
        reset = 1'b0;
        #1;
        chk("midrst_col",  col_out,   4'b1110);
        chk("midrst_tipo", tipo,      1'b1);
        chk("midrst_num",  number,    4'b1110);
        chk("midrst_kv",   key_valid, 1'b0);
        chk("midrst_held", key_held,  1'b0);
        chk("midrst_ev",   8'(ev_cnt), 8'd0);
        @(negedge clk) reset = 1'b1;

        // key still held after reset is accepted: c0 none, c1 accept, 2 more matches
        wait_tick(4);
        chk("p5_kv",   key_valid, 1'b1);
        chk("p5_tipo", tipo,      1'b0);
        chk("p5_num",  number,    4'd5);
        chk("p5_col",  col_out,   4'b1101);
        chk("p5_held_before", key_held, 1'b0);
        @(posedge clk); #1;
        chk("p5_kv_drop",  key_valid, 1'b0);
        chk("p5_held",     key_held,  1'b1);
        chk("p5_idle_tip", tipo,      1'b1);
        chk("p5_idle_num", number,    4'b1110);
        wait_tick(16);
        chk("p5_one_event", 8'(ev_cnt), 8'd1);
        chk("p5_held_long", key_held,   1'b1);
        chk("p5_col_long",  col_out,    4'b1101);
        pressed = 16'h0;
        wait_tick(2);
        chk("p5_rel2_held", key_held, 1'b1);
        wait_tick(1);
        chk("p5_rel3_held", key_held, 1'b0);
        chk("p5_rel_col",   col_out,  4'b1011);

        // r2c3 ("="): bounce on the second sample
        pressed = 16'h0800;
        wait_col(4'b0111);
        wait_tick(1);
        pressed = 16'h0;
        wait_tick(1);
        chk("b_col_adv", col_out,    4'b1110);
        chk("b_no_ev",   8'(ev_cnt), 8'd1);
        chk("b_held",    key_held,   1'b0);
        pressed = 16'h0800;
        wait_tick(8);
        chk("b_ev",   8'(ev_cnt), 8'd2);
        chk("b_tipo", last_tipo,  1'b1);
        chk("b_num",  last_num,   4'b1100);
        chk("b_held_on", key_held, 1'b1);
        pressed = 16'h0;
        wait_tick(1);
        pressed = 16'h0800;
        wait_tick(1);
        pressed = 16'h0;
        wait_tick(2);
        chk("b_relbounce_held", key_held, 1'b1);
        wait_tick(1);
        chk("b_rel_done", key_held,   1'b0);
        chk("b_rel_ev",   8'(ev_cnt), 8'd2);
        wait_tick(2);

        // r0c0 + r1c0 together: multi-key reads as none
        pressed = 16'h0011;
        wait_tick(12);
        chk("mk_no_ev", 8'(ev_cnt), 8'd2);
        chk("mk_held",  key_held,   1'b0);
        wait_col(4'b1110);
        wait_tick(1);
        chk("mk_scan", col_out, 4'b1101);
        pressed = 16'h0001;
        wait_tick(8);
        chk("mk_ev",   8'(ev_cnt), 8'd3);
        chk("mk_tipo", last_tipo,  1'b0);
        chk("mk_num",  last_num,   4'd1);
        pressed = 16'h0;
        wait_tick(5);
        chk("mk_rel", key_held, 1'b0);

        // r3c2 unused, then r3c0 reset-key
        pressed = 16'h4000;
        wait_tick(10);
        chk("unused_ev",   8'(ev_cnt), 8'd3);
        chk("unused_held", key_held,   1'b0);
        pressed = 16'h1000;
        wait_tick(8);
        chk("rk_ev",   8'(ev_cnt), 8'd4);
        chk("rk_tipo", last_tipo,  1'b1);
        chk("rk_num",  last_num,   4'b1111);
        wait_tick(8);
        chk("rk_no_repeat", 8'(ev_cnt), 8'd4);
        pressed = 16'h0;
        wait_tick(5);

        // r0c2 ("3") held 14 samples from accept
        ev_base = ev_cnt;
        pressed = 16'h0004;
        wait_kv();
        wait_tick(6);
`ifdef KEY_REPEAT_EN
        chk("d3_first_repeat", key_valid, 1'b1);
`else
        chk("d3_no_repeat", key_valid, 1'b0);
`endif
        wait_tick(7);
        pressed = 16'h0;
        wait_tick(5);
`ifdef KEY_REPEAT_EN
        chk("d3_events", 8'(ev_cnt - ev_base), 8'd5);
`else
        chk("d3_events", 8'(ev_cnt - ev_base), 8'd1);
`endif
        chk("d3_tipo", last_tipo, 1'b0);
        chk("d3_num",  last_num,  4'd3);
        chk("d3_rel",  key_held,  1'b0);

        // r0c3 ("+") held the same time: sign keys never repeat
        ev_base = ev_cnt;
        pressed = 16'h0008;
        wait_kv();
        wait_tick(13);
        pressed = 16'h0;
        wait_tick(5);
        chk("plus_events", 8'(ev_cnt - ev_base), 8'd1);
        chk("plus_tipo",   last_tipo, 1'b1);
        chk("plus_num",    last_num,  4'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
